// File: rtl/addsub_seq.sv
// ---------------------------------------------------------------------------
// addsub_seq
//
// Slice-serial two's-complement adder/subtractor for the Beta ALU.
// One SLICE-bit chunk is added per clock, LSB slice first. A carry register
// links consecutive slices, so the full-width carry chain never sits in a
// single cycle. The registered Z/V/N flags feed the CMPEQ/CMPLT/CMPLE logic
// of the compare unit.
//
// Subtraction is A + ~B + 1. B is inverted when it is latched, and the
// carry register is seeded with the sub bit. The datapath itself is
// therefore always a plain adder.
//
// Ports
//   clk    in   1      clock; all state changes on the rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request; sampled only while ready=1
//   sub    in   1      0: A+B, 1: A-B; sampled with start
//   a      in   WIDTH  operand A; sampled with start
//   b      in   WIDTH  operand B; sampled with start
//   ready  out  1      idle and able to accept start (= ~busy)
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse; s/z/v/n were updated this cycle
//   s      out  WIDTH  result, modulo 2^WIDTH
//   z      out  1      result is zero
//   v      out  1      two's-complement overflow
//   n      out  1      result MSB
// ---------------------------------------------------------------------------
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  // The slice walk only covers the whole word when SLICE divides WIDTH.
  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("addsub_seq: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One slice of the ripple: returns {carry_out, sum}.
  function automatic logic [SLICE:0] slice_add(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             cin
  );
    slice_add = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
  endfunction

  // Signed overflow: both addends have the same sign and the sum's sign differs.
  function automatic logic add_ovf(
    input logic x_msb,
    input logic y_msb,
    input logic r_msb
  );
    add_ovf = (x_msb & y_msb & ~r_msb) | (~x_msb & ~y_msb & r_msb);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;   // already inverted for subtraction
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] opa_sl_s;
  logic [SLICE-1:0] opb_sl_s;
  logic [SLICE:0]   slice_sum_s;
  logic [WIDTH-1:0] acc_upd_s;
  logic             last_s;

  // Pick out the current slice of each operand (an AND-OR mux, one term per slice).
  always_comb begin
    opa_sl_s = {SLICE{1'b0}};
    opb_sl_s = {SLICE{1'b0}};
    for (int i = 0; i < NSLICE; i++) begin
      opa_sl_s = opa_sl_s | (opa_q[i*SLICE +: SLICE] & {SLICE{cnt_q == CNT_W'(i)}});
      opb_sl_s = opb_sl_s | (opb_q[i*SLICE +: SLICE] & {SLICE{cnt_q == CNT_W'(i)}});
    end
  end

  // Add the current slice and merge it into the accumulator image.
  always_comb begin
    slice_sum_s = slice_add(opa_sl_s, opb_sl_s, carry_q);
    last_s      = (cnt_q == LAST_CNT);
    acc_upd_s   = acc_q;
    for (int i = 0; i < NSLICE; i++) begin
      acc_upd_s[i*SLICE +: SLICE] = (cnt_q == CNT_W'(i)) ? slice_sum_s[SLICE-1:0]
                                                          : acc_q[i*SLICE +: SLICE];
    end
  end

  // Next-state logic for the control FSM and the datapath.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    s_d     = s_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start == 1'b1) begin
          state_d = ST_RUN;
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;            // the +1 of A + ~B + 1
          cnt_d   = {CNT_W{1'b0}};
          acc_d   = {WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        acc_d   = acc_upd_s;
        carry_d = slice_sum_s[SLICE];
        if (last_s == 1'b1) begin
          // The final carry-out is dropped: results wrap modulo 2^WIDTH.
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          s_d     = acc_upd_s;
          z_d     = (acc_upd_s == {WIDTH{1'b0}});
          n_d     = acc_upd_s[WIDTH-1];
          v_d     = add_ovf(opa_q[WIDTH-1], opb_q[WIDTH-1], acc_upd_s[WIDTH-1]);
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign ready = ~busy;
  assign done  = done_q;
  assign s     = s_q;
  assign z     = z_q;
  assign v     = v_q;
  assign n     = n_q;

endmodule

// File: tb/tb_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_addsub_seq
//
// Directed and random operations on addsub_seq. Expected results come from
// plain 32-bit and 64-bit signed arithmetic on the operands. Each operation
// also checks the handshake: latency from the start edge to done, the number
// of busy cycles, and that the flags hold steady until completion.
// ---------------------------------------------------------------------------
module tb_addsub_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        z;
  logic        v;
  logic        n;

  int n_cmp;
  int n_fail;

  // Last result the model says the DUT should be presenting.
  logic [31:0] prev_s;
  logic        prev_z;
  logic        prev_v;
  logic        prev_n;

  addsub_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .z     (z),
    .v     (v),
    .n     (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference result: wrap-around 32-bit add or subtract.
  function automatic logic [31:0] ref_s(input logic sb, input logic [31:0] aa, input logic [31:0] bb);
    ref_s = sb ? (aa - bb) : (aa + bb);
  endfunction

  // Reference overflow: the exact signed result falls outside the 32-bit range.
  function automatic logic ref_v(input logic sb, input logic [31:0] aa, input logic [31:0] bb);
    longint sa;
    longint sb2;
    longint r;
    sa  = longint'($signed(aa));
    sb2 = longint'($signed(bb));
    r   = sb ? (sa - sb2) : (sa + sb2);
    ref_v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Start one operation at a falling edge while ready. Return at the falling
  // edge where done is high. With poke set, a start carrying different
  // operands is pulsed during RUN and must be ignored.
  task automatic run_op(input string tag, input logic sb, input logic [31:0] aa,
                        input logic [31:0] bb, input bit poke);
    int          cyc;
    int          busy_cyc;
    bit          hold_ok;
    logic [31:0] es;
    start = 1'b1;
    sub   = sb;
    a     = aa;
    b     = bb;
    @(negedge clk);
    // Operands are latched; scramble the inputs to show that.
    start    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    sub      = 1'($urandom);
    cyc      = 0;
    busy_cyc = 0;
    hold_ok  = 1'b1;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cyc++;
      if (s !== prev_s || z !== prev_z || v !== prev_v || n !== prev_n) hold_ok = 1'b0;
      if (poke && cyc == 1) begin
        start = 1'b1;
        sub   = ~sb;
        a     = ~aa;
        b     = bb + 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    es = ref_s(sb, aa, bb);
    chk_int({tag, " latency"}, cyc, 4);
    chk_int({tag, " busy_cycles"}, busy_cyc, 4);
    chk1({tag, " flags_held"}, hold_ok, 1'b1);
    chk1({tag, " ready_at_done"}, ready, 1'b1);
    chk32({tag, " s"}, s, es);
    chk1({tag, " z"}, z, (es == 32'd0));
    chk1({tag, " v"}, v, ref_v(sb, aa, bb));
    chk1({tag, " n"}, n, es[31]);
    prev_s = es;
    prev_z = (es == 32'd0);
    prev_v = ref_v(sb, aa, bb);
    prev_n = es[31];
  endtask

  initial begin
    bit no_done;
    n_cmp  = 0;
    n_fail = 0;
    prev_s = 32'd0;
    prev_z = 1'b0;
    prev_v = 1'b0;
    prev_n = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    a      = 32'd0;
    b      = 32'd0;

    // Values while held in reset.
    repeat (2) @(negedge clk);
    chk32("reset s", s, 32'd0);
    chk1("reset z", z, 1'b0);
    chk1("reset v", v, 1'b0);
    chk1("reset n", n, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset ready", ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic subtraction and the compare-oriented cases.
    run_op("5-3", 1'b1, 32'd5, 32'd3, 1'b0);
    @(negedge clk);
    run_op("3-5", 1'b1, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    run_op("7-7", 1'b1, 32'd7, 32'd7, 1'b0);
    @(negedge clk);

    // Carries that cross slice boundaries.
    run_op("ff+1", 1'b0, 32'h0000_00FF, 32'd1, 1'b0);
    @(negedge clk);
    run_op("ffffff+1", 1'b0, 32'h00FF_FFFF, 32'd1, 1'b0);
    @(negedge clk);
    run_op("wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    @(negedge clk);

    // Signed overflow in both directions.
    run_op("ovf_add", 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    @(negedge clk);
    run_op("ovf_sub", 1'b1, 32'h8000_0000, 32'd1, 1'b0);
    @(negedge clk);
    run_op("sub_min", 1'b1, 32'd0, 32'h8000_0000, 1'b0);
    @(negedge clk);

    // A start pulsed during RUN is ignored.
    run_op("poke", 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    // The next start comes in the done cycle itself: accepted, and flags hold in between.
    run_op("b2b_1", 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    run_op("b2b_2", 1'b0, 32'hDEAD_BEEF, 32'h0102_0304, 1'b0);

    // Random operations, each launched in the previous op's done cycle.
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 1'($urandom), $urandom, $urandom, 1'(i % 5 == 0));
    end
    @(negedge clk);

    // Leave non-zero flags, then reset during the second RUN cycle.
    run_op("pre_rst", 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    a     = 32'h0000_1234;
    b     = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk32("midrst s", s, 32'd0);
    chk1("midrst z", z, 1'b0);
    chk1("midrst v", v, 1'b0);
    chk1("midrst n", n, 1'b0);
    chk1("midrst busy", busy, 1'b0);
    chk1("midrst done", done, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    prev_s  = 32'd0;
    prev_z  = 1'b0;
    prev_v  = 1'b0;
    prev_n  = 1'b0;
    no_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || ready !== 1'b1) no_done = 1'b0;
    end
    chk1("postrst quiet", no_done, 1'b1);

    // The unit still works after the abort.
    run_op("post_rst_op", 1'b1, 32'd100, 32'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
